// File: rtl/alu_multicycle_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_multicycle_if
// Purpose  : Start/Busy/Done handshake plus operand and result bus between
//            the pipeline controller (master) and the multicycle ALU (slave).
// Revision : 1.0  initial release
// ============================================================================
interface alu_multicycle_if #(
  parameter int WIDTH = 16
);
  logic             i_start;
  logic [2:0]       i_op;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_result;
  logic             o_zero;
  logic             o_carry;
  logic             o_overflow;

  modport master (
    output i_start, i_op, i_a, i_b,
    input  o_busy, o_done, o_result, o_zero, o_carry, o_overflow
  );

  modport slave (
    input  i_start, i_op, i_a, i_b,
    output o_busy, o_done, o_result, o_zero, o_carry, o_overflow
  );
endinterface
`default_nettype wire

// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : alu_multicycle
// Purpose  : ALU stage behind the ALU control decoder. Logic/ADD/SUB finish
//            in one cycle; ROR/SLL step one bit per clock and MUL does one
//            shift-add step per clock. Result and flags change only on the
//            edge that enters DONE and are held otherwise.
// Revision : 1.0  initial release
// ============================================================================
module alu_multicycle #(
  parameter int WIDTH     = 16,
  parameter int MUL_STEPS = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,
  alu_multicycle_if.slave    bus
);

  localparam int c_SHW  = $clog2(WIDTH);
  localparam int c_CNTW = $clog2(MUL_STEPS) + 1;

  localparam logic [c_CNTW-1:0] c_CNT_ONE = c_CNTW'(1);
  localparam logic [c_CNTW-1:0] c_CNT_MUL = c_CNTW'(MUL_STEPS);

  localparam logic [2:0] c_OP_AND = 3'b000;
  localparam logic [2:0] c_OP_OR  = 3'b001;
  localparam logic [2:0] c_OP_ADD = 3'b010;
  localparam logic [2:0] c_OP_XOR = 3'b011;
  localparam logic [2:0] c_OP_SLL = 3'b100;
  localparam logic [2:0] c_OP_ROR = 3'b101;
  localparam logic [2:0] c_OP_SUB = 3'b110;
  localparam logic [2:0] c_OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_MUL   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_ror;
  logic [WIDTH-1:0]      r_work;
  logic [2*WIDTH-1:0]    r_acc;
  logic [2*WIDTH-1:0]    r_mcand;
  logic [WIDTH-1:0]      r_mplier;
  logic [c_CNTW-1:0]     r_count;
  logic [WIDTH-1:0]      r_result;
  logic                  r_zero;
  logic                  r_carry;
  logic                  r_overflow;

  logic                  w_accept;
  logic                  w_is_mul;
  logic                  w_is_shift;
  logic [c_SHW-1:0]      w_shamt;
  logic [WIDTH:0]        w_sum;
  logic [WIDTH:0]        w_dif;
  logic [WIDTH-1:0]      w_fast_res;
  logic                  w_fast_c;
  logic                  w_fast_v;
  logic [WIDTH-1:0]      w_work_step;
  logic [2*WIDTH-1:0]    w_acc_step;
  logic                  w_busy;
  logic                  w_done;

  // A new operation is taken in IDLE and, for back-to-back issue, in DONE.
  assign w_accept   = bus.i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_is_mul   = (bus.i_op == c_OP_MUL);
  assign w_is_shift = (bus.i_op == c_OP_ROR) || (bus.i_op == c_OP_SLL);
  assign w_shamt    = bus.i_b[c_SHW-1:0];
  assign w_sum      = {1'b0, bus.i_a} + {1'b0, bus.i_b};
  assign w_dif      = {1'b0, bus.i_a} - {1'b0, bus.i_b};

  assign w_work_step = r_ror ? {r_work[0], r_work[WIDTH-1:1]}
                             : {r_work[WIDTH-2:0], 1'b0};
  assign w_acc_step  = r_acc + (r_mplier[0] ? r_mcand : '0);

  // Single-cycle result and flags; zero-length shifts pass A through.
  always_comb begin
    w_fast_res = bus.i_a;
    w_fast_c   = 1'b0;
    w_fast_v   = 1'b0;
    case (bus.i_op)
      c_OP_AND: w_fast_res = bus.i_a & bus.i_b;
      c_OP_OR:  w_fast_res = bus.i_a | bus.i_b;
      c_OP_XOR: w_fast_res = bus.i_a ^ bus.i_b;
      c_OP_ADD: begin
        w_fast_res = w_sum[WIDTH-1:0];
        w_fast_c   = w_sum[WIDTH];
        w_fast_v   = (bus.i_a[WIDTH-1] == bus.i_b[WIDTH-1]) &&
                     (w_sum[WIDTH-1] != bus.i_a[WIDTH-1]);
      end
      c_OP_SUB: begin
        w_fast_res = w_dif[WIDTH-1:0];
        w_fast_c   = w_dif[WIDTH];
        w_fast_v   = (bus.i_a[WIDTH-1] == ~bus.i_b[WIDTH-1]) &&
                     (w_dif[WIDTH-1] != bus.i_a[WIDTH-1]);
      end
      default: w_fast_res = bus.i_a;
    endcase
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_done = (r_state == S_DONE);
        if (w_accept) begin
          if (w_is_mul)
            w_state_nxt = S_MUL;
          else if (w_is_shift && (w_shamt != '0))
            w_state_nxt = S_SHIFT;
          else
            w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SHIFT, S_MUL: begin
        w_busy = 1'b1;
        if (r_count == c_CNT_ONE)
          w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Operand latching, iteration datapath and result/flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ror      <= 1'b0;
      r_work     <= '0;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_count    <= '0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_ror <= (bus.i_op == c_OP_ROR);
            if (w_is_mul) begin
              r_acc    <= '0;
              r_mcand  <= {{WIDTH{1'b0}}, bus.i_a};
              r_mplier <= bus.i_b;
              r_count  <= c_CNT_MUL;
            end else if (w_is_shift && (w_shamt != '0)) begin
              r_work  <= bus.i_a;
              r_count <= {{(c_CNTW-c_SHW){1'b0}}, w_shamt};
            end else begin
              r_result   <= w_fast_res;
              r_zero     <= (w_fast_res == '0);
              r_carry    <= w_fast_c;
              r_overflow <= w_fast_v;
            end
          end
        end
        S_SHIFT: begin
          r_work  <= w_work_step;
          r_count <= r_count - c_CNT_ONE;
          if (r_count == c_CNT_ONE) begin
            r_result   <= w_work_step;
            r_zero     <= (w_work_step == '0);
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_step;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count - c_CNT_ONE;
          if (r_count == c_CNT_ONE) begin
            r_result   <= w_acc_step[WIDTH-1:0];
            r_zero     <= (w_acc_step[WIDTH-1:0] == '0);
            r_carry    <= 1'b0;
            r_overflow <= |w_acc_step[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_busy     = w_busy;
  assign bus.o_done     = w_done;
  assign bus.o_result   = r_result;
  assign bus.o_zero     = r_zero;
  assign bus.o_carry    = r_carry;
  assign bus.o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_multicycle
// Purpose  : Scoreboard bench for alu_multicycle. Expected result, flags and
//            latency are queued when an operation is issued and compared
//            when Done is observed.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_multicycle;

  localparam logic [2:0] c_OP_AND = 3'b000;
  localparam logic [2:0] c_OP_OR  = 3'b001;
  localparam logic [2:0] c_OP_ADD = 3'b010;
  localparam logic [2:0] c_OP_XOR = 3'b011;
  localparam logic [2:0] c_OP_SLL = 3'b100;
  localparam logic [2:0] c_OP_ROR = 3'b101;
  localparam logic [2:0] c_OP_SUB = 3'b110;
  localparam logic [2:0] c_OP_MUL = 3'b111;

  typedef struct {
    logic [15:0] res;
    logic        z;
    logic        c;
    logic        v;
    int          lat;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  exp_t r_q[$];

  alu_multicycle_if #(.WIDTH(16)) bus ();

  alu_multicycle #(.WIDTH(16), .MUL_STEPS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    logic [16:0] s;
    logic [31:0] p;
    int          n;
    n     = int'(b[3:0]);
    e.res = '0;
    e.c   = 1'b0;
    e.v   = 1'b0;
    e.lat = 1;
    case (op)
      c_OP_AND: e.res = a & b;
      c_OP_OR:  e.res = a | b;
      c_OP_XOR: e.res = a ^ b;
      c_OP_ADD: begin
        s     = {1'b0, a} + {1'b0, b};
        e.res = s[15:0];
        e.c   = s[16];
        e.v   = (a[15] == b[15]) && (e.res[15] != a[15]);
      end
      c_OP_SUB: begin
        e.res = a - b;
        e.c   = (a < b);
        e.v   = (a[15] != b[15]) && (e.res[15] != a[15]);
      end
      c_OP_ROR: begin
        e.res = (n == 0) ? a : ((a >> n) | (a << (16 - n)));
        e.lat = n + 1;
      end
      c_OP_SLL: begin
        e.res = a << n;
        e.lat = n + 1;
      end
      default: begin
        p     = {16'h0, a} * {16'h0, b};
        e.res = p[15:0];
        e.v   = |p[31:16];
        e.lat = 17;
      end
    endcase
    e.z = (e.res == 16'h0);
    return e;
  endfunction

  // Called at a falling edge: presents a request for the next rising edge.
  task automatic drive(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input bit push);
    bus.i_start = 1'b1;
    bus.i_op    = op;
    bus.i_a     = a;
    bus.i_b     = b;
    if (push) r_q.push_back(model(op, a, b));
  endtask

  // Waits for Done, scrambling inputs after acceptance; optionally injects
  // an AND request at falling edge number 'inject' while the op runs.
  task automatic wait_done(input string tag, input int inject);
    exp_t e;
    int   cnt;
    bit   seen;
    if (r_q.size() == 0) begin
      chk({tag, " queue"}, 32'd0, 32'd1);
      return;
    end
    e    = r_q.pop_front();
    cnt  = 0;
    seen = 1'b0;
    while (!seen && cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) chk({tag, " busy"}, {31'd0, bus.o_busy}, {31'd0, (e.lat > 1)});
      if (bus.o_done) seen = 1'b1;
      bus.i_start = (inject != 0) && (cnt == inject);
      bus.i_op    = ((inject != 0) && (cnt == inject)) ? c_OP_AND : 3'($urandom_range(0, 7));
      bus.i_a     = 16'($urandom);
      bus.i_b     = 16'($urandom);
    end
    chk({tag, " done seen"}, {31'd0, seen}, 32'd1);
    chk({tag, " latency"}, cnt, e.lat);
    chk({tag, " result"}, {16'd0, bus.o_result}, {16'd0, e.res});
    chk({tag, " flags"}, {29'd0, bus.o_zero, bus.o_carry, bus.o_overflow},
        {29'd0, e.z, e.c, e.v});
  endtask

  task automatic expect_done_low(input string tag);
    @(negedge clk);
    chk({tag, " done pulse"}, {31'd0, bus.o_done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    bit          any_done;
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    // A request raised during reset must be ignored.
    bus.i_start = 1'b1;
    bus.i_op    = c_OP_MUL;
    bus.i_a     = 16'h1234;
    bus.i_b     = 16'h5678;
    repeat (3) @(negedge clk);
    rst         = 1'b0;
    bus.i_start = 1'b0;
    @(negedge clk);
    chk("reset busy", {31'd0, bus.o_busy}, 32'd0);
    chk("reset done", {31'd0, bus.o_done}, 32'd0);
    chk("reset result", {16'd0, bus.o_result}, 32'd0);
    chk("reset flags", {29'd0, bus.o_zero, bus.o_carry, bus.o_overflow}, 32'd0);

    drive(c_OP_ADD, 16'h7FFF, 16'h0001, 1'b1);
    wait_done("add ovf", 0);
    expect_done_low("add ovf");
    drive(c_OP_SUB, 16'h0005, 16'h0005, 1'b1);
    wait_done("sub zero", 0);
    expect_done_low("sub zero");
    drive(c_OP_SUB, 16'h0003, 16'h0005, 1'b1);
    wait_done("sub borrow", 0);
    expect_done_low("sub borrow");
    drive(c_OP_ROR, 16'h0001, 16'h0004, 1'b1);
    wait_done("ror 4", 0);
    expect_done_low("ror 4");
    drive(c_OP_SLL, 16'h8001, 16'h0000, 1'b1);
    wait_done("sll 0", 0);
    expect_done_low("sll 0");
    drive(c_OP_MUL, 16'h0123, 16'h0045, 1'b1);
    wait_done("mul", 0);
    expect_done_low("mul");
    drive(c_OP_MUL, 16'h0100, 16'h0100, 1'b1);
    wait_done("mul ovf", 0);
    expect_done_low("mul ovf");
    drive(c_OP_ROR, 16'h8421, 16'h001F, 1'b1);
    wait_done("ror 15", 0);
    expect_done_low("ror 15");
    drive(c_OP_ADD, 16'hFFFF, 16'h0001, 1'b1);
    wait_done("add carry", 0);
    expect_done_low("add carry");

    for (int i = 0; i < 16; i++) begin
      op = 3'(i % 8);
      a  = 16'($urandom);
      b  = 16'($urandom);
      drive(op, a, b, 1'b1);
      wait_done("random", 0);
    end
    expect_done_low("random");

    // Start during Busy is dropped; Start in DONE is taken back-to-back.
    drive(c_OP_MUL, 16'h0003, 16'h0005, 1'b1);
    wait_done("mul drop", 4);
    drive(c_OP_XOR, 16'h00FF, 16'h0F0F, 1'b1);
    wait_done("xor b2b", 0);
    expect_done_low("xor b2b");

    // Reset in the middle of a multiply.
    drive(c_OP_MUL, 16'h1234, 16'h0011, 1'b0);
    repeat (8) begin
      @(negedge clk);
      bus.i_start = 1'b0;
    end
    chk("mid mul busy", {31'd0, bus.o_busy}, 32'd1);
    chk("mid mul hold", {16'd0, bus.o_result}, 32'h0FF0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid rst busy", {31'd0, bus.o_busy}, 32'd0);
    chk("mid rst done", {31'd0, bus.o_done}, 32'd0);
    chk("mid rst result", {16'd0, bus.o_result}, 32'd0);
    any_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.o_done) any_done = 1'b1;
    end
    chk("no done after rst", {31'd0, any_done}, 32'd0);

    drive(c_OP_OR, 16'hA000, 16'h000A, 1'b1);
    wait_done("or recover", 0);
    expect_done_low("or recover");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
